// File: rtl/psum_accumulator_if.sv
// Handshake/bus bundle between the systolic-array drain stage and the partial-sum buffer.
// The master side drives collection and read requests; the slave side answers.
interface psum_accumulator_if #(
  parameter int COLS  = 4,
  parameter int DEPTH = 16,
  parameter int SUM_W = 16,
  parameter int ACC_W = 32
);
  localparam int AW = $clog2(DEPTH);

  logic                    start;
  logic                    acc_mode;
  logic [COLS-1:0]         col_valid;
  logic [COLS*SUM_W-1:0]   mac_in;
  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic [COLS*ACC_W-1:0]   rd_data;
  logic                    rd_valid;
  logic                    busy;
  logic                    done;
  logic                    overflow;

  modport master (
    output start, acc_mode, col_valid, mac_in, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, done, overflow
  );

  modport slave (
    input  start, acc_mode, col_valid, mac_in, rd_en, rd_addr,
    output rd_data, rd_valid, busy, done, overflow
  );
endinterface

// File: rtl/psum_accumulator.sv
// Deskewing partial-sum buffer: each column writes or accumulates its own stream of
// mac_out results into a DEPTH x COLS accumulator array, read back one row per cycle.
module psum_accumulator #(
  parameter int COLS  = 4,
  parameter int DEPTH = 16,
  parameter int SUM_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  psum_accumulator_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_FINISH  = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic                        mode_q, mode_d;
  logic                        ovf_q, ovf_d;
  logic [COLS-1:0]             cmpl_q, cmpl_d;
  logic [AW-1:0]               wp_q [COLS];
  logic [AW-1:0]               wp_d [COLS];
  logic signed [ACC_W-1:0]     buf_q [DEPTH][COLS];
  logic signed [ACC_W-1:0]     buf_d [DEPTH][COLS];
  logic [COLS*ACC_W-1:0]       rd_data_q, rd_data_d;
  logic                        rd_valid_q, rd_valid_d;
  logic signed [ACC_W-1:0]     wr_val;
  logic                        busy;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [SUM_W-1:0] x);
    return {{(ACC_W-SUM_W){x[SUM_W-1]}}, x};
  endfunction

  // Accumulation wraps modulo 2^ACC_W; no saturation.
  function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
    return a + b;
  endfunction

  assign busy = (state_q == S_COLLECT);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    cmpl_d  = cmpl_q;
    wp_d    = wp_q;
    buf_d   = buf_q;
    wr_val  = '0;

    // start wins over everything, including same-cycle column writes
    if (bus.start) begin
      state_d = S_COLLECT;
      mode_d  = bus.acc_mode;
      ovf_d   = 1'b0;
      cmpl_d  = '0;
      for (int c = 0; c < COLS; c++) wp_d[c] = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          for (int c = 0; c < COLS; c++) begin
            if (bus.col_valid[c]) begin
              if (cmpl_q[c]) begin
                ovf_d = 1'b1;
              end else begin
                wr_val = sext(bus.mac_in[c*SUM_W +: SUM_W]);
                buf_d[wp_q[c]][c] = mode_q ? wrap_add(buf_q[wp_q[c]][c], wr_val) : wr_val;
                wp_d[c] = wp_q[c] + 1'b1;
                if (wp_q[c] == AW'(DEPTH-1)) cmpl_d[c] = 1'b1;
              end
            end
          end
          if (&cmpl_d) state_d = S_FINISH;
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_valid_d = bus.rd_en && !busy;
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      for (int c = 0; c < COLS; c++) rd_data_d[c*ACC_W +: ACC_W] = buf_q[bus.rd_addr][c];
    end
  end

  // ---- register boundary: control, buffer and read stage ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cmpl_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int c = 0; c < COLS; c++) wp_q[c] <= '0;
      for (int r = 0; r < DEPTH; r++)
        for (int c = 0; c < COLS; c++) buf_q[r][c] <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      ovf_q      <= ovf_d;
      cmpl_q     <= cmpl_d;
      wp_q       <= wp_d;
      buf_q      <= buf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = (state_q == S_FINISH);
  assign bus.overflow = ovf_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: drives skewed column passes, keeps a buffer
// model, and compares every returned row against queued expectations.
`timescale 1ns/1ps
module tb_psum_accumulator;
  localparam int COLS  = 4;
  localparam int DEPTH = 16;
  localparam int SUM_W = 16;
  localparam int ACC_W = 32;
  localparam int LAST_K = DEPTH + COLS - 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic cur_mode;

  logic [COLS*ACC_W-1:0] exp_q [$];
  logic [ACC_W-1:0]      model [DEPTH][COLS];

  psum_accumulator_if #(.COLS(COLS), .DEPTH(DEPTH), .SUM_W(SUM_W), .ACC_W(ACC_W)) bus ();

  psum_accumulator #(.COLS(COLS), .DEPTH(DEPTH), .SUM_W(SUM_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [COLS*ACC_W-1:0] obs,
                     input logic [COLS*ACC_W-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [SUM_W-1:0] dval(input int kind, input int r, input int c);
    case (kind)
      0: return SUM_W'(16 * r + c);
      1: return (r == 0 && c == 0) ? 16'hFFFF : 16'h0000;
      2: return (r == 0 && c == 0) ? 16'h0001 : 16'h0000;
      3: return SUM_W'(16'h0100 + r);
      default: return SUM_W'(16'h0300 + 16 * r + c);
    endcase
  endfunction

  function automatic logic [COLS*ACC_W-1:0] model_row(input int r);
    logic [COLS*ACC_W-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*ACC_W +: ACC_W] = model[r][c];
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.rd_valid === 1'b1) begin
      if (exp_q.size() > 0) chk("rd_data", bus.rd_data, exp_q.pop_front());
      else chk("rd_spurious", 1, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic read_row(input int addr, input logic [COLS*ACC_W-1:0] expv);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr[$clog2(DEPTH)-1:0];
    exp_q.push_back(expv);
    @(posedge clk); #1;
    bus.rd_en   = 1'b0;
  endtask

  task automatic start_pass(input logic mode, input logic [COLS-1:0] junk_cv);
    bus.start     = 1'b1;
    bus.acc_mode  = mode;
    bus.col_valid = junk_cv;
    bus.mac_in    = {COLS{16'h0BAD}};
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.col_valid = '0;
    bus.mac_in    = '0;
    cur_mode      = mode;
    chk("start_busy", bus.busy, 1);
    chk("start_ovf_clr", bus.overflow, 0);
  endtask

  task automatic collect(input int kind, input bit extra0, input int ncyc, input bit rd_during);
    logic [COLS-1:0]       cv;
    logic [COLS*SUM_W-1:0] mac;
    logic [SUM_W-1:0]      v;
    for (int k = 0; k < ncyc; k++) begin
      cv  = '0;
      mac = '0;
      for (int c = 0; c < COLS; c++) begin
        if (k >= c && k < c + DEPTH) begin
          v = dval(kind, k - c, c);
          cv[c] = 1'b1;
          mac[c*SUM_W +: SUM_W] = v;
          if (cur_mode) model[k-c][c] = model[k-c][c] + {{(ACC_W-SUM_W){v[SUM_W-1]}}, v};
          else          model[k-c][c] = {{(ACC_W-SUM_W){v[SUM_W-1]}}, v};
        end
      end
      if (extra0 && k == DEPTH) begin
        cv[0] = 1'b1;
        mac[SUM_W-1:0] = 16'h7777;
      end
      bus.col_valid = cv;
      bus.mac_in    = mac;
      bus.rd_en     = rd_during && (k == 2);
      bus.rd_addr   = '0;
      @(posedge clk); #1;
      chk($sformatf("done_k%0d", k), bus.done, (k == LAST_K));
      if (rd_during && k == 2) chk("rd_blocked", bus.rd_valid, 0);
      if (k == LAST_K) begin
        chk("finish_busy", bus.busy, 0);
        chk("finish_ovf", bus.overflow, extra0);
      end
    end
    bus.col_valid = '0;
    bus.mac_in    = '0;
    bus.rd_en     = 1'b0;
    if (ncyc == LAST_K + 1) begin
      @(posedge clk); #1;
      chk("done_pulse_end", bus.done, 0);
      chk("idle_busy", bus.busy, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.acc_mode = 1'b0; bus.col_valid = '0; bus.mac_in = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    cur_mode = 1'b0;
    for (int r = 0; r < DEPTH; r++) for (int c = 0; c < COLS; c++) model[r][c] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    read_row(3, '0);

    // overwrite pass, then full back-to-back readback
    start_pass(1'b0, '0);
    collect(0, 1'b0, LAST_K + 1, 1'b0);
    read_row(5, {32'h53, 32'h52, 32'h51, 32'h50});
    for (int r = 0; r < DEPTH; r++) read_row(r, model_row(r));

    // accumulate the same data
    start_pass(1'b1, '0);
    collect(0, 1'b0, LAST_K + 1, 1'b0);
    read_row(5, {32'hA6, 32'hA4, 32'hA2, 32'hA0});

    // sign extension and modulo wrap
    start_pass(1'b0, '0);
    collect(1, 1'b0, LAST_K + 1, 1'b0);
    read_row(0, {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF});
    start_pass(1'b1, '0);
    collect(2, 1'b0, LAST_K + 1, 1'b0);
    read_row(0, {32'h0, 32'h0, 32'h0, 32'h0});
    read_row(5, model_row(5));

    // overflow: 17th valid on column 0 while column 1 still filling
    start_pass(1'b0, '0);
    collect(0, 1'b1, LAST_K + 1, 1'b0);
    read_row(0, {32'h3, 32'h2, 32'h1, 32'h0});

    // restart mid-pass, read attempt while busy, junk valids in the restart cycle
    start_pass(1'b0, '0);
    collect(3, 1'b0, 8, 1'b1);
    start_pass(1'b0, '1);
    collect(4, 1'b0, LAST_K + 1, 1'b0);
    read_row(0, model_row(0));
    read_row(8, model_row(8));
    read_row(15, model_row(15));

    // asynchronous reset during collection
    start_pass(1'b1, '0);
    collect(0, 1'b0, 5, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_ovf", bus.overflow, 0);
    chk("arst_rd_valid", bus.rd_valid, 0);
    chk("arst_rd_data", bus.rd_data, 0);
    for (int r = 0; r < DEPTH; r++) for (int c = 0; c < COLS; c++) model[r][c] = '0;
    #3 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", bus.busy, 0);
    read_row(0, '0);
    read_row(5, '0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream of the PE systolic array. Captures the 16-bit mac_out results leaving the bottom PE of each column.
- Column c results arrive skewed c cycles after column 0; each column is tracked independently, which deskews them.
- Results are stored in, or accumulated into, a DEPTH x COLS buffer of wide accumulators, so partial sums from successive weight tiles add up.
- The buffer is read back row by row by the output/writeback stage.

Parameters:
- COLS, 4, number of array columns feeding the block.
- DEPTH, 16, result rows per column (power of two).
- SUM_W, 16, width of each mac_out input (signed two's complement).
- ACC_W, 32, accumulator width per entry (ACC_W > SUM_W).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a collection pass.
- acc_mode  in  1  sampled at start; 0 = overwrite, 1 = accumulate.
- col_valid  in  COLS  bit c qualifies column c of mac_in this cycle.
- mac_in  in  COLS*SUM_W  column c occupies bits [c*SUM_W +: SUM_W].
- rd_en  in  1  read request.
- rd_addr  in  log2(DEPTH)  buffer row to read.
- rd_data  out  COLS*ACC_W  row contents; column c occupies bits [c*ACC_W +: ACC_W].
- rd_valid  out  1  rd_data is valid this cycle.
- busy  out  1  collection pass in progress.
- done  out  1  one-cycle pulse when every column has written DEPTH entries.
- overflow  out  1  sticky; a column_valid arrived for an already-complete column.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All buffer entries, write pointers, column-complete flags and latched mode are cleared to 0.
  - rd_data, rd_valid, busy, done and overflow are all 0.
- States: IDLE, COLLECT, FINISH.
- IDLE:
  - start=1 -> COLLECT.
  - acc_mode is latched.
  - Write pointers wp[0..COLS-1] and complete flags are cleared.
  - overflow is cleared.
  - busy=1 from the next cycle.
- COLLECT, per column c independently, on col_valid[c]=1 and complete[c]=0:
  - Write value: x = sign-extend(mac_in[c]) to ACC_W.
  - Overwrite mode: entry[wp[c]][c] <= x.
  - Accumulate mode: entry[wp[c]][c] <= entry[wp[c]][c] + x, modulo 2^ACC_W (wraps, no saturation).
  - Then wp[c] increments.
  - The write at wp[c]=DEPTH-1 sets complete[c]; wp[c] wraps to 0.
- COLLECT, col_valid[c]=1 while complete[c]=1: write is ignored and overflow is set (sticky until the next accepted start or reset).
- COLLECT exit: the cycle all complete flags are 1 (after that cycle's writes), go to FINISH.
- FINISH, one cycle:
  - done=1 and busy=0.
  - Next state is IDLE.
- start while in COLLECT restarts the pass:
  - Pointers, flags and overflow are cleared; acc_mode is re-latched.
  - Buffer contents are retained.
  - col_valid in that same cycle is ignored (start has priority).
- start in FINISH: done still pulses; start is treated as an IDLE start in the same cycle and the next state is COLLECT.
- col_valid in IDLE or FINISH is ignored; overflow is not set.
- Read port:
  - rd_en=1 with busy=0 -> rd_data = entry[rd_addr] and rd_valid=1 the following cycle (1-cycle latency).
  - rd_en while busy=1 is dropped: rd_valid=0 and rd_data holds its previous value.
  - Back-to-back reads give one row per cycle.
- Reset mid-pass discards the pass and clears the buffer immediately.

Test Plan:
- Overwrite, COLS=4, DEPTH=16:
  - Stimulus: start (acc_mode=0); column c gets col_valid for 16 cycles starting at cycle c, with mac_in = 16'h0010*r + c for row r.
  - Required: done pulses exactly one cycle after column 3's 16th write.
  - Required: reading row 5 returns {32'h53, 32'h52, 32'h51, 32'h50} (col3..col0).
- Accumulate:
  - Stimulus: repeat the previous pass with acc_mode=1 and identical data.
  - Required: row 5 reads {32'hA6, 32'hA4, 32'hA2, 32'hA0}.
- Sign extension / wrap:
  - Stimulus: column 0 writes 16'hFFFF in overwrite mode, then 16'h0001 in accumulate mode.
  - Required: the entry reads 32'hFFFFFFFF after the first pass and 32'h00000000 after the second.
- Overflow:
  - Stimulus: give column 0 a 17th col_valid while column 1 is still incomplete.
  - Required: overflow=1; row 0 of column 0 is unchanged; done still fires after the other columns complete.
- Restart and read blocking:
  - Stimulus: start mid-pass after column 0 has written 8 rows.
  - Required: wp resets, so the next write lands in row 0.
  - Stimulus: rd_en while busy.
  - Required: rd_valid stays 0.
- Async reset:
  - Stimulus: assert reset between clock edges during COLLECT.
  - Required: busy, done, overflow and rd_valid drop immediately; any read afterwards returns all zeros.
